// File: rtl/reg_native_arb_pkg.sv
// Shared types and helpers for the reg_native round-robin arbiter.
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // All-ones read-data pattern returned on a downstream timeout; sliced to DATA_WIDTH.
  localparam int unsigned RD_ERR_MAX_W = 1024;
  localparam logic [RD_ERR_MAX_W-1:0] RD_ERR_VAL = '1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_native_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module reg_native_rr_arb
  import reg_native_arb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int IDX_W = idx_width(N_MST)
) (
  input  logic [N_MST-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_MST-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < N_MST; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_MST)) begin
        sum = sum - (IDX_W+1)'(N_MST);
      end
      pos = sum[IDX_W-1:0];
      if (!gnt_vld && req[pos]) begin
        gnt_vld  = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/reg_native_arb.sv
// Round-robin arbiter sharing one reg_native slave among N_MST masters, one transaction in flight.
// Optional WAIT-state timeout is enabled by defining REG_NATIVE_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winning master's command
// ISSUE | downstream req_vld asserted for exactly one cycle
// WAIT  | waiting for downstream ack_vld
// RESP  | one-cycle mst_ack_vld pulse to the granted master
module reg_native_arb
  import reg_native_arb_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 64,
  parameter int  DATA_WIDTH  = 32,
  parameter int  N_MST       = 2,
  parameter int  TIMEOUT_CYC = 255,
  localparam int IDX_W       = idx_width(N_MST)
) (
  input  logic                        fsm_clk,
  input  logic                        fsm_rstn,
  input  logic [N_MST-1:0]            mst_req_vld,
  input  logic [N_MST-1:0]            mst_wr_en,
  input  logic [N_MST-1:0]            mst_rd_en,
  input  logic [N_MST*ADDR_WIDTH-1:0] mst_addr,
  input  logic [N_MST*DATA_WIDTH-1:0] mst_wr_data,
  output logic [N_MST-1:0]            mst_ack_vld,
  output logic [DATA_WIDTH-1:0]       mst_rd_data,
  output logic                        req_vld,
  output logic                        wr_en,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        ack_vld,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        busy,
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
  output logic                        timeout_err,
`endif
  output logic [IDX_W-1:0]            grant_id
);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [N_MST-1:0]      gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  sel_wr, sel_rd;
  logic                  load_req, cap_rdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q, rd_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [N_MST-1:0]      ack_vec;

  logic [ADDR_WIDTH-1:0] addr_arr  [N_MST];
  logic [DATA_WIDTH-1:0] wdata_arr [N_MST];

  for (genvar i = 0; i < N_MST; i++) begin : g_unpack
    assign addr_arr[i]  = mst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = mst_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  reg_native_rr_arb #(
    .N_MST (N_MST),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (mst_req_vld),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Write wins when both enables are set, so a read is only issued when wr_en is low.
  assign sel_wr = |(gnt & mst_wr_en);
  assign sel_rd = |(gnt & mst_rd_en) & ~sel_wr;

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 256) ? 8 : 16;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_flag_q;
  logic            to_hit;

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
      end else if (state_q == WAIT && to_cnt_q != '0) begin
        to_cnt_q <= to_cnt_q - TO_W'(1);
      end
      if (load_req) begin
        to_flag_q <= 1'b0;
      end else if (to_hit) begin
        to_flag_q <= 1'b1;
      end
    end
  end

  assign timeout_err = (state_q == RESP) && to_flag_q;
`endif

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_req  = 1'b0;
    cap_rdata = 1'b0;
    rdata_d   = rdata_q;
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          load_req = 1'b1;
          if (sel_wr || sel_rd) begin
            state_d = ISSUE;
          end else begin
            state_d   = RESP;
            cap_rdata = 1'b1;
            rdata_d   = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        if (ack_vld) begin
          state_d   = RESP;
          cap_rdata = 1'b1;
          rdata_d   = wr_q ? '0 : rd_data;
        end
      end
      WAIT: begin
        if (ack_vld) begin
          state_d   = RESP;
          cap_rdata = 1'b1;
          rdata_d   = wr_q ? '0 : rd_data;
        end
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
        else if (to_cnt_q == '0) begin
          state_d   = RESP;
          cap_rdata = 1'b1;
          rdata_d   = RD_ERR_VAL[DATA_WIDTH-1:0];
          to_hit    = 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (load_req) begin
        grant_q <= gnt_idx;
        ptr_q   <= (gnt_idx == IDX_W'(N_MST - 1)) ? '0 : gnt_idx + IDX_W'(1);
        addr_q  <= addr_arr[gnt_idx];
        wdata_q <= wdata_arr[gnt_idx];
        wr_q    <= sel_wr;
        rd_q    <= sel_rd;
      end
      if (cap_rdata) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_comb begin
    ack_vec = '0;
    if (state_q == RESP) begin
      ack_vec[grant_q] = 1'b1;
    end
  end

  assign mst_ack_vld = ack_vec;
  assign mst_rd_data = rdata_q;
  assign req_vld     = (state_q == ISSUE);
  assign wr_en       = wr_q;
  assign rd_en       = rd_q;
  assign addr        = addr_q;
  assign wr_data     = wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_reg_native_arb.sv
// Directed self-checking bench for reg_native_arb (2 masters, TIMEOUT_CYC=16).
module tb_reg_native_arb;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int NM = 2;

  logic             fsm_clk;
  logic             fsm_rstn;
  logic [NM-1:0]    mst_req_vld;
  logic [NM-1:0]    mst_wr_en;
  logic [NM-1:0]    mst_rd_en;
  logic [NM*AW-1:0] mst_addr;
  logic [NM*DW-1:0] mst_wr_data;
  logic [NM-1:0]    mst_ack_vld;
  logic [DW-1:0]    mst_rd_data;
  logic             req_vld;
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wr_data;
  logic             ack_vld;
  logic [DW-1:0]    rd_data;
  logic             busy;
  logic             grant_id;
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  reg_native_arb #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .N_MST       (NM),
    .TIMEOUT_CYC (16)
  ) dut (
    .fsm_clk     (fsm_clk),
    .fsm_rstn    (fsm_rstn),
    .mst_req_vld (mst_req_vld),
    .mst_wr_en   (mst_wr_en),
    .mst_rd_en   (mst_rd_en),
    .mst_addr    (mst_addr),
    .mst_wr_data (mst_wr_data),
    .mst_ack_vld (mst_ack_vld),
    .mst_rd_data (mst_rd_data),
    .req_vld     (req_vld),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .ack_vld     (ack_vld),
    .rd_data     (rd_data),
    .busy        (busy),
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .grant_id    (grant_id)
  );

  initial fsm_clk = 1'b0;
  always #5 fsm_clk = ~fsm_clk;

  task automatic tick();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic set_mst(input int m, input logic vld, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    mst_req_vld[m]          = vld;
    mst_wr_en[m]            = wr;
    mst_rd_en[m]            = rd;
    mst_addr[m*AW +: AW]    = a;
    mst_wr_data[m*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    fsm_rstn    = 1'b0;
    mst_req_vld = '0;
    mst_wr_en   = '0;
    mst_rd_en   = '0;
    mst_addr    = '0;
    mst_wr_data = '0;
    ack_vld     = 1'b0;
    rd_data     = '0;
    repeat (2) @(posedge fsm_clk);
    #1;
  endtask

  task automatic release_reset();
    fsm_rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL rst_req_vld got=%h exp=0", req_vld); end
    total++; if (mst_ack_vld !== 2'b00) begin bad++; $display("FAIL rst_mst_ack got=%h exp=0", mst_ack_vld); end
    total++; if ({wr_en, rd_en, grant_id} !== 3'b000) begin bad++; $display("FAIL rst_cmd_gid got=%b exp=000", {wr_en, rd_en, grant_id}); end
    total++; if (addr !== 64'h0 || wr_data !== 32'h0 || mst_rd_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", addr, wr_data, mst_rd_data); end
    release_reset();
  endtask

  task automatic test_single_write();
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b1, 1'b0, 64'h10, 32'h1111_1111);
    tick();
    total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL wr_req_vld got=%h exp=1", req_vld); end
    total++; if (addr !== 64'h10 || wr_data !== 32'h1111_1111) begin bad++; $display("FAIL wr_addr_data got=%h/%h exp=10/11111111", addr, wr_data); end
    total++; if ({wr_en, rd_en, grant_id} !== 3'b100) begin bad++; $display("FAIL wr_cmd got=%b exp=100", {wr_en, rd_en, grant_id}); end
    tick();
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL wr_req_one_cycle got=%h exp=0", req_vld); end
    tick();
    tick();
    ack_vld = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    total++; if (mst_ack_vld !== 2'b00 || busy !== 1'b1 || addr !== 64'h10) begin bad++; $display("FAIL wr_wait got=%h/%h/%h exp=0/1/10", mst_ack_vld, busy, addr); end
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b01) begin bad++; $display("FAIL wr_ack got=%h exp=01", mst_ack_vld); end
    total++; if (mst_rd_data !== 32'h0) begin bad++; $display("FAIL wr_rdata_zero got=%h exp=0", mst_rd_data); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total++; if (busy !== 1'b0 || mst_ack_vld !== 2'b00) begin bad++; $display("FAIL wr_done got=%h/%h exp=0/0", busy, mst_ack_vld); end
  endtask

  task automatic test_two_reads();
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b0, 1'b1, 64'h20, 32'h0);
    set_mst(1, 1'b1, 1'b0, 1'b1, 64'h24, 32'h0);
    tick();
    total++; if (grant_id !== 1'b0 || addr !== 64'h20 || {wr_en, rd_en} !== 2'b01) begin bad++; $display("FAIL rd0_issue got=%h/%h/%b exp=0/20/01", grant_id, addr, {wr_en, rd_en}); end
    tick();
    ack_vld = 1'b1;
    rd_data = 32'hAAAA_AAAA;
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b01 || mst_rd_data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL rd0_resp got=%h/%h exp=01/aaaaaaaa", mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    tick();
    total++; if (grant_id !== 1'b1 || addr !== 64'h24 || req_vld !== 1'b1) begin bad++; $display("FAIL rd1_issue got=%h/%h/%h exp=1/24/1", grant_id, addr, req_vld); end
    tick();
    ack_vld = 1'b1;
    rd_data = 32'h5555_5555;
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b10 || mst_rd_data !== 32'h5555_5555) begin bad++; $display("FAIL rd1_resp got=%h/%h exp=10/55555555", mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total++; if (mst_rd_data !== 32'h5555_5555 || busy !== 1'b0) begin bad++; $display("FAIL rd_hold got=%h/%h exp=55555555/0", mst_rd_data, busy); end
  endtask

  task automatic test_back_to_back();
    logic       exp_gid;
    logic [1:0] exp_ack;
    logic [63:0] exp_addr;
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b0, 1'b1, 64'h100, 32'h0);
    set_mst(1, 1'b1, 1'b0, 1'b1, 64'h200, 32'h0);
    for (int n = 0; n < 6; n++) begin
      exp_gid  = n[0];
      exp_ack  = exp_gid ? 2'b10 : 2'b01;
      exp_addr = exp_gid ? 64'h200 : 64'h100;
      tick();
      total++; if (grant_id !== exp_gid || addr !== exp_addr) begin bad++; $display("FAIL b2b_grant n=%0d got=%h/%h exp=%h/%h", n, grant_id, addr, exp_gid, exp_addr); end
      ack_vld = 1'b1;
      rd_data = 32'h100 + 32'(n);
      tick();
      ack_vld = 1'b0;
      total++; if (mst_ack_vld !== exp_ack || mst_rd_data !== 32'h100 + 32'(n)) begin bad++; $display("FAIL b2b_ack n=%0d got=%h/%h exp=%h/%h", n, mst_ack_vld, mst_rd_data, exp_ack, 32'h100 + 32'(n)); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle n=%0d got=%h exp=0", n, busy); end
    end
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    set_mst(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic test_zero_latency();
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b0, 1'b1, 64'h40, 32'h0);
    tick();
    total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL zl_req got=%h exp=1", req_vld); end
    ack_vld = 1'b1;
    rd_data = 32'h1234_5678;
    tick();
    ack_vld = 1'b0;
    total++; if (req_vld !== 1'b0 || mst_ack_vld !== 2'b01 || mst_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL zl_resp got=%h/%h/%h exp=0/01/12345678", req_vld, mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total++; if (busy !== 1'b0 || req_vld !== 1'b0) begin bad++; $display("FAIL zl_idle got=%h/%h exp=0/0", busy, req_vld); end
    tick();
    total++; if (req_vld !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zl_no_reissue got=%h/%h exp=0/0", req_vld, busy); end
  endtask

  task automatic test_noop();
    set_mst(0, 1'b1, 1'b0, 1'b0, 64'h50, 32'h0);
    tick();
    total++; if (req_vld !== 1'b0 || mst_ack_vld !== 2'b01 || mst_rd_data !== 32'h0) begin bad++; $display("FAIL noop_resp got=%h/%h/%h exp=0/01/0", req_vld, mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total++; if (req_vld !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL noop_idle got=%h/%h exp=0/0", req_vld, busy); end
  endtask

  task automatic test_wr_rd_both();
    set_mst(1, 1'b1, 1'b1, 1'b1, 64'h60, 32'hCAFE_F00D);
    tick();
    total++; if ({wr_en, rd_en, grant_id} !== 3'b101 || wr_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL both_cmd got=%b/%h exp=101/cafef00d", {wr_en, rd_en, grant_id}, wr_data); end
    ack_vld = 1'b1;
    rd_data = 32'h9999_9999;
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b10 || mst_rd_data !== 32'h0) begin bad++; $display("FAIL both_resp got=%h/%h exp=10/0", mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic test_ack_ignored();
    ack_vld = 1'b1;
    rd_data = 32'h7777_7777;
    tick();
    ack_vld = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || mst_ack_vld !== 2'b00 || mst_rd_data !== 32'h0) begin bad++; $display("FAIL idle_ack got=%h/%h/%h exp=0/0/0", busy, mst_ack_vld, mst_rd_data); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b1, 1'b0, 64'h70, 32'h7777_0000);
    tick();
    tick();
    total++; if (busy !== 1'b1 || req_vld !== 1'b0) begin bad++; $display("FAIL mid_wait got=%h/%h exp=1/0", busy, req_vld); end
    fsm_rstn    = 1'b0;
    mst_req_vld = '0;
    #1;
    total++; if ({busy, req_vld, wr_en, rd_en, grant_id, mst_ack_vld} !== 7'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b exp=0", {busy, req_vld, wr_en, rd_en, grant_id, mst_ack_vld}); end
    total++; if (addr !== 64'h0 || wr_data !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", addr, wr_data); end
    @(posedge fsm_clk);
    #1;
    fsm_rstn = 1'b1;
    set_mst(0, 1'b1, 1'b0, 1'b1, 64'h80, 32'h0);
    set_mst(1, 1'b1, 1'b0, 1'b1, 64'h84, 32'h0);
    tick();
    total++; if (grant_id !== 1'b0 || addr !== 64'h80) begin bad++; $display("FAIL mid_first_grant got=%h/%h exp=0/80", grant_id, addr); end
    ack_vld = 1'b1;
    rd_data = 32'h0000_0BAD;
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b01) begin bad++; $display("FAIL mid_ack0 got=%h exp=01", mst_ack_vld); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    tick();
    ack_vld = 1'b1;
    rd_data = 32'h0000_0F00;
    tick();
    ack_vld = 1'b0;
    total++; if (mst_ack_vld !== 2'b10 || mst_rd_data !== 32'h0000_0F00) begin bad++; $display("FAIL mid_ack1 got=%h/%h exp=10/f00", mst_ack_vld, mst_rd_data); end
    tick();
    set_mst(1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    release_reset();
    set_mst(0, 1'b1, 1'b0, 1'b1, 64'h90, 32'h0);
    tick();
    repeat (16) tick();
    total++; if (busy !== 1'b1 || mst_ack_vld !== 2'b00 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_wait got=%h/%h/%h exp=1/0/0", busy, mst_ack_vld, timeout_err); end
    tick();
    total++; if (mst_ack_vld !== 2'b01 || mst_rd_data !== 32'hFFFF_FFFF || timeout_err !== 1'b1) begin bad++; $display("FAIL to_resp got=%h/%h/%h exp=01/ffffffff/1", mst_ack_vld, mst_rd_data, timeout_err); end
    tick();
    set_mst(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse got=%h/%h exp=0/0", timeout_err, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_two_reads();
    test_back_to_back();
    test_zero_latency();
    test_noop();
    test_wr_rd_both();
    test_ack_ignored();
    test_reset_mid();
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
